ls_arbiter: RTL and testbench
=============================

# ls_arbiter

Arbiter that shares the single-ported SPU Local Store between three requesters: the DMA engine (MFC), the load/store unit (LSU) and instruction fetch (IFU). It grants one access per cycle, drives the Local Store memory port, and returns registered read data with a one-cycle-later valid strobe to the granted reader. It sits between the SPU pipeline/MFC and the Local Store memory module.

## Interface
- WIDTH, 32, data and address width
- STARVE_LIMIT, 8, consecutive denied IFU cycles before the IFU is promoted (1..15)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- dma_req, dma_we  in  1  DMA request / write enable
- dma_adr, dma_wdata  in  WIDTH  DMA byte address / write data
- dma_gnt  out  1  DMA granted this cycle
- dma_rvalid  out  1  rdata holds DMA read result
- lsu_req, lsu_we  in  1  LSU request / write enable
- lsu_adr, lsu_wdata  in  WIDTH  LSU byte address / write data
- lsu_gnt, lsu_rvalid  out  1  LSU grant / read valid
- ifu_req  in  1  IFU read request (read-only requester)
- ifu_adr  in  WIDTH  IFU byte address
- ifu_gnt, ifu_rvalid  out  1  IFU grant / read valid
- rdata  out  WIDTH  registered read data, shared by all requesters
- mem_write  out  1  Local Store write enable
- mem_adr, mem_wdata  out  WIDTH  Local Store address / write data
- mem_rdata  in  WIDTH  Local Store combinational read data

## Operation
- Requester asserts req with adr/we/wdata stable; holds them until it sees gnt high in the same cycle. Request completes on the edge where gnt is high.
- At most one gnt high per cycle; gnt is combinational from req and arbiter state.
- Base priority: DMA > LSU > IFU.
- Starvation: counter starve_cnt increments each cycle ifu_req=1 and ifu_gnt=0, saturating at STARVE_LIMIT; cleared when ifu_gnt=1 or ifu_req=0. When starve_cnt==STARVE_LIMIT and ifu_req=1, IFU wins over DMA and LSU that cycle.
- Mux: mem_adr/mem_wdata/mem_write follow the granted requester; mem_write = granted_we (always 0 for IFU). No grant: mem_write=0, mem_adr=0, mem_wdata=0.
- Reads: on edge of a granted read, rdata <= mem_rdata and the granted requester's rvalid <= 1 for exactly one cycle. rdata holds its value until the next granted read.
- Writes: no rvalid; rdata unchanged. Memory writes on the same edge.
- Address bits [1:0] passed through unchanged; word alignment is the memory's responsibility.

## Timing
- Grant: 0 cycles (same cycle as req when winning).
- Read latency: rvalid and rdata one cycle after gnt.
- Back-to-back: a requester may hold req high and receive gnt every cycle; consecutive reads give consecutive rvalid pulses.
- Simultaneous req from all three: DMA granted; LSU next if DMA drops; IFU after starve_cnt saturates.
- Reset (async, mid-operation included): rdata=0, all rvalid=0, starve_cnt=0 immediately; all gnt=0 and mem_write=0 while rst_n=0. A read granted in the cycle reset asserts produces no rvalid.
- First edge after rst_n rises: normal arbitration.

## Configuration
- LS_ARB_STARVE_EN defined: starvation counter and IFU promotion as above.
- Not defined: strict fixed priority DMA > LSU > IFU; starve_cnt not implemented; IFU may wait indefinitely; STARVE_LIMIT ignored.

## Test plan
- Single IFU read adr=0x10, memory word 4 = 0xDEADBEEF -> ifu_gnt same cycle, next cycle ifu_rvalid=1, rdata=0xDEADBEEF.
- LSU write adr=0x20 data=0x12345678, then IFU read adr=0x20 -> write on first edge, IFU rdata=0x12345678 one cycle after its grant.
- DMA, LSU, IFU all request in same cycle, held -> gnt order DMA, then LSU after DMA drops; never two gnts in one cycle.
- With LS_ARB_STARVE_EN, STARVE_LIMIT=8, DMA and IFU held high continuously -> IFU denied 8 cycles, granted on cycle 9, counter clears, DMA resumes; without macro IFU never granted.
- Assert rst_n=0 mid-cycle during a granted LSU read -> gnt, rvalid, rdata drop to 0 immediately; no rvalid after release.
- Alternating DMA read/LSU write every cycle for 16 cycles -> dma_rvalid only after DMA read grants, lsu_rvalid never asserted.

Source files
------------

// File: rtl/ls_arbiter_if.sv
// Local Store arbiter bus: three requester ports, shared read data and the
// Local Store memory port. master = requester/memory side, slave = arbiter.
interface ls_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             dma_req;
  logic             dma_we;
  logic [WIDTH-1:0] dma_adr;
  logic [WIDTH-1:0] dma_wdata;
  logic             dma_gnt;
  logic             dma_rvalid;
  logic             lsu_req;
  logic             lsu_we;
  logic [WIDTH-1:0] lsu_adr;
  logic [WIDTH-1:0] lsu_wdata;
  logic             lsu_gnt;
  logic             lsu_rvalid;
  logic             ifu_req;
  logic [WIDTH-1:0] ifu_adr;
  logic             ifu_gnt;
  logic             ifu_rvalid;
  logic [WIDTH-1:0] rdata;
  logic             mem_write;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;

  modport slave (
    input  dma_req, dma_we, dma_adr, dma_wdata,
    input  lsu_req, lsu_we, lsu_adr, lsu_wdata,
    input  ifu_req, ifu_adr, mem_rdata,
    output dma_gnt, dma_rvalid, lsu_gnt, lsu_rvalid, ifu_gnt, ifu_rvalid,
    output rdata, mem_write, mem_adr, mem_wdata
  );

  modport master (
    output dma_req, dma_we, dma_adr, dma_wdata,
    output lsu_req, lsu_we, lsu_adr, lsu_wdata,
    output ifu_req, ifu_adr, mem_rdata,
    input  dma_gnt, dma_rvalid, lsu_gnt, lsu_rvalid, ifu_gnt, ifu_rvalid,
    input  rdata, mem_write, mem_adr, mem_wdata
  );
endinterface

// File: rtl/ls_arbiter.sv
// SPU Local Store arbiter: DMA > LSU > IFU, one access per cycle, registered read data.
// Define LS_ARB_STARVE_EN to promote a starved IFU after STARVE_LIMIT denied cycles.
module ls_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 8
) (
  input logic         clk,
  input logic         rst_n,
  ls_arbiter_if.slave bus
);

  logic             w_dma_gnt;
  logic             w_lsu_gnt;
  logic             w_ifu_gnt;
  logic             w_ifu_promote;
  logic             w_mem_write;
  logic [WIDTH-1:0] w_mem_adr;
  logic [WIDTH-1:0] w_mem_wdata;
  logic             w_read;
  logic             r_dma_rvalid;
  logic             r_lsu_rvalid;
  logic             r_ifu_rvalid;
  logic [WIDTH-1:0] r_rdata;

`ifdef LS_ARB_STARVE_EN
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve_cnt;

  assign w_ifu_promote = bus.ifu_req && (r_starve_cnt == LP_LIMIT);

  // Count consecutive denied IFU cycles, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
    end else if (!bus.ifu_req || w_ifu_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != LP_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_ifu_promote = 1'b0;
`endif

  // Grant selection; no grant at all while reset is asserted
  always_comb begin
    w_dma_gnt = 1'b0;
    w_lsu_gnt = 1'b0;
    w_ifu_gnt = 1'b0;
    if (!rst_n) begin
      w_dma_gnt = 1'b0;
    end else if (w_ifu_promote) begin
      w_ifu_gnt = 1'b1;
    end else if (bus.dma_req) begin
      w_dma_gnt = 1'b1;
    end else if (bus.lsu_req) begin
      w_lsu_gnt = 1'b1;
    end else if (bus.ifu_req) begin
      w_ifu_gnt = 1'b1;
    end else begin
      w_dma_gnt = 1'b0;
    end
  end

  // Memory port follows the winner; idle port is driven to zero
  always_comb begin
    w_mem_write = 1'b0;
    w_mem_adr   = '0;
    w_mem_wdata = '0;
    if (w_dma_gnt) begin
      w_mem_write = bus.dma_we;
      w_mem_adr   = bus.dma_adr;
      w_mem_wdata = bus.dma_wdata;
    end else if (w_lsu_gnt) begin
      w_mem_write = bus.lsu_we;
      w_mem_adr   = bus.lsu_adr;
      w_mem_wdata = bus.lsu_wdata;
    end else if (w_ifu_gnt) begin
      w_mem_adr   = bus.ifu_adr;
    end else begin
      w_mem_write = 1'b0;
    end
  end

  assign w_read = (w_dma_gnt || w_lsu_gnt || w_ifu_gnt) && !w_mem_write;

  // Capture read data and pulse the winner's rvalid one cycle after the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dma_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_ifu_rvalid <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_dma_rvalid <= w_dma_gnt && !bus.dma_we;
      r_lsu_rvalid <= w_lsu_gnt && !bus.lsu_we;
      r_ifu_rvalid <= w_ifu_gnt;
      if (w_read) begin
        r_rdata <= bus.mem_rdata;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.lsu_gnt    = w_lsu_gnt;
  assign bus.ifu_gnt    = w_ifu_gnt;
  assign bus.dma_rvalid = r_dma_rvalid;
  assign bus.lsu_rvalid = r_lsu_rvalid;
  assign bus.ifu_rvalid = r_ifu_rvalid;
  assign bus.rdata      = r_rdata;
  assign bus.mem_write  = w_mem_write;
  assign bus.mem_adr    = w_mem_adr;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed testbench for ls_arbiter with a small Local Store memory model.
module tb_ls_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ls_arbiter_if #(.WIDTH(32)) bus ();

  ls_arbiter #(.WIDTH(32), .STARVE_LIMIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Local Store model: preloaded pattern, word 4 = 0xDEADBEEF
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_adr[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
      mem[4] <= 32'hDEAD_BEEF;
    end else if (bus.mem_write) begin
      mem[bus.mem_adr[9:2]] <= bus.mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_adr = 32'h0; bus.dma_wdata = 32'h0;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_adr = 32'h0; bus.lsu_wdata = 32'h0;
    bus.ifu_req = 1'b0; bus.ifu_adr = 32'h0;
  endtask

  function automatic logic [31:0] ngnt();
    return 32'(bus.dma_gnt) + 32'(bus.lsu_gnt) + 32'(bus.ifu_gnt);
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle_all();
    rst_n = 1'b0;
    bus.dma_req = 1'b1;
    #3;
    check("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_rvalid", 32'({bus.dma_rvalid, bus.lsu_rvalid, bus.ifu_rvalid}), 32'd0);
    step();
    rst_n = 1'b1;
    bus.dma_req = 1'b0;

    // Single IFU read of word 4
    step();
    bus.ifu_req = 1'b1; bus.ifu_adr = 32'h10;
    @(negedge clk);
    check("t1_ifu_gnt", 32'(bus.ifu_gnt), 32'd1);
    check("t1_mem_adr", bus.mem_adr, 32'h10);
    check("t1_mem_write", 32'(bus.mem_write), 32'd0);
    step();
    bus.ifu_req = 1'b0;
    @(negedge clk);
    check("t1_ifu_rvalid", 32'(bus.ifu_rvalid), 32'd1);
    check("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
    check("t1_idle_adr", bus.mem_adr, 32'h0);
    step();
    @(negedge clk);
    check("t1_rvalid_pulse", 32'(bus.ifu_rvalid), 32'd0);
    check("t1_rdata_hold", bus.rdata, 32'hDEAD_BEEF);

    // LSU write then IFU read-back
    step();
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_adr = 32'h20; bus.lsu_wdata = 32'h1234_5678;
    @(negedge clk);
    check("t2_lsu_gnt", 32'(bus.lsu_gnt), 32'd1);
    check("t2_mem_write", 32'(bus.mem_write), 32'd1);
    check("t2_mem_wdata", bus.mem_wdata, 32'h1234_5678);
    step();
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0;
    bus.ifu_req = 1'b1; bus.ifu_adr = 32'h20;
    @(negedge clk);
    check("t2_ifu_gnt", 32'(bus.ifu_gnt), 32'd1);
    check("t2_lsu_rvalid", 32'(bus.lsu_rvalid), 32'd0);
    check("t2_rdata_kept", bus.rdata, 32'hDEAD_BEEF);
    step();
    bus.ifu_req = 1'b0;
    @(negedge clk);
    check("t2_ifu_rvalid", 32'(bus.ifu_rvalid), 32'd1);
    check("t2_rdata", bus.rdata, 32'h1234_5678);

    // All three request reads together
    step();
    bus.dma_req = 1'b1; bus.dma_adr = 32'h40;
    bus.lsu_req = 1'b1; bus.lsu_adr = 32'h44;
    bus.ifu_req = 1'b1; bus.ifu_adr = 32'h48;
    @(negedge clk);
    check("t3_c1_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    check("t3_c1_onehot", ngnt(), 32'd1);
    step();
    @(negedge clk);
    check("t3_c2_dma_gnt", 32'(bus.dma_gnt), 32'd1);
    check("t3_c2_onehot", ngnt(), 32'd1);
    check("t3_c2_dma_rvalid", 32'(bus.dma_rvalid), 32'd1);
    check("t3_c2_rdata", bus.rdata, 32'h5A00_0010);
    step();
    bus.dma_req = 1'b0;
    @(negedge clk);
    check("t3_c3_lsu_gnt", 32'(bus.lsu_gnt), 32'd1);
    check("t3_c3_onehot", ngnt(), 32'd1);
    step();
    bus.lsu_req = 1'b0;
    @(negedge clk);
    check("t3_c4_ifu_gnt", 32'(bus.ifu_gnt), 32'd1);
    check("t3_c4_lsu_rvalid", 32'(bus.lsu_rvalid), 32'd1);
    check("t3_c4_rdata", bus.rdata, 32'h5A00_0011);
    step();
    bus.ifu_req = 1'b0;
    @(negedge clk);
    check("t3_c5_ifu_rvalid", 32'(bus.ifu_rvalid), 32'd1);
    check("t3_c5_rdata", bus.rdata, 32'h5A00_0012);

    // DMA and IFU held: starvation behaviour
    step();
    bus.dma_req = 1'b1; bus.dma_adr = 32'h40;
    bus.ifu_req = 1'b1; bus.ifu_adr = 32'h10;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
`ifdef LS_ARB_STARVE_EN
      check($sformatf("t4_c%0d_ifu_gnt", c), 32'(bus.ifu_gnt), (c == 9) ? 32'd1 : 32'd0);
      check($sformatf("t4_c%0d_dma_gnt", c), 32'(bus.dma_gnt), (c == 9) ? 32'd0 : 32'd1);
      if (c == 10) begin
        check("t4_ifu_rvalid", 32'(bus.ifu_rvalid), 32'd1);
        check("t4_rdata", bus.rdata, 32'hDEAD_BEEF);
      end
`else
      check($sformatf("t4_c%0d_ifu_gnt", c), 32'(bus.ifu_gnt), 32'd0);
      check($sformatf("t4_c%0d_dma_gnt", c), 32'(bus.dma_gnt), 32'd1);
`endif
      check($sformatf("t4_c%0d_onehot", c), ngnt(), 32'd1);
      step();
    end
    idle_all();

    // Reset asserted mid-cycle while an LSU read is granted and rvalid is high
    step();
    bus.lsu_req = 1'b1; bus.lsu_adr = 32'h44;
    step();
    @(negedge clk);
    check("t5_lsu_gnt", 32'(bus.lsu_gnt), 32'd1);
    check("t5_lsu_rvalid", 32'(bus.lsu_rvalid), 32'd1);
    check("t5_rdata", bus.rdata, 32'h5A00_0011);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_gnt", 32'(bus.lsu_gnt), 32'd0);
    check("t5_rst_rvalid", 32'(bus.lsu_rvalid), 32'd0);
    check("t5_rst_rdata", bus.rdata, 32'h0);
    check("t5_rst_mem_write", 32'(bus.mem_write), 32'd0);
    step();
    bus.lsu_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_post_rvalid", 32'(bus.lsu_rvalid), 32'd0);
    check("t5_post_rdata", bus.rdata, 32'h0);

    // Alternating DMA read / LSU write for 16 cycles
    step();
    for (int i = 0; i < 17; i++) begin
      idle_all();
      if (i < 16 && (i % 2) == 0) begin
        bus.dma_req = 1'b1; bus.dma_adr = 32'h80 + 32'(4 * i);
      end else if (i < 16) begin
        bus.lsu_req = 1'b1; bus.lsu_we = 1'b1;
        bus.lsu_adr = 32'hC0 + 32'(4 * i); bus.lsu_wdata = 32'hC0DE_0000 + 32'(i);
      end
      @(negedge clk);
      check($sformatf("t6_i%0d_dma_rvalid", i), 32'(bus.dma_rvalid), (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("t6_i%0d_lsu_rvalid", i), 32'(bus.lsu_rvalid), 32'd0);
      if (i % 2 == 1)
        check($sformatf("t6_i%0d_rdata", i), bus.rdata, 32'h5A00_0020 + 32'(i - 1));
      if (i < 16)
        check($sformatf("t6_i%0d_gnt", i), 32'({bus.dma_gnt, bus.lsu_gnt}), (i % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end
    check("t6_write_word1", mem[49], 32'hC0DE_0001);
    check("t6_write_word15", mem[63], 32'hC0DE_000F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
